// File: rtl/mips_pkg.sv
// Shared definitions for the write-back stage.
//   - source-select codes for the write-back data mux
//   - load-type codes for load alignment/extension
//   - default depth of the pending-write buffer
//   - the buffered write-back entry layout
package mips_pkg;

  localparam int WB_DEPTH_DEFAULT = 2;

  // Offset added to the instruction address to form the link value
  // (return address skips the branch and its delay slot).
  localparam logic [31:0] LINK_OFFSET = 32'd8;

  typedef enum logic [1:0] {
    SEL_ALU     = 2'd0,
    SEL_LOAD    = 2'd1,
    SEL_LINK    = 2'd2,
    SEL_ALU_ALT = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LBU = 3'd1,
    LD_LH  = 3'd2,
    LD_LHU = 3'd3,
    LD_LW  = 3'd4
  } load_type_e;

  typedef struct packed {
    logic        wen;
    logic [4:0]  wreg;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Load alignment and sign/zero extension (purely combinational).
// Ports:
//   rdata     in  32  raw memory word
//   addr_lo   in   2  low bits of the load address
//   load_type in   3  LB/LBU/LH/LHU/LW; codes above LW behave as LW
//   data      out 32  aligned, extended load result
module wb_load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte lane selected by the full low address.
  always_comb begin
    byte_s = 8'd0;
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'd0;
    endcase
  end

  // Halfword lane; addr_lo[0] is deliberately ignored for halfwords.
  always_comb begin
    half_s = 16'd0;
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extension by load type; unknown codes fall through to a full word.
  always_comb begin
    data = rdata;
    case (load_type)
      LD_LB:   data = {{24{byte_s[7]}}, byte_s};
      LD_LBU:  data = {24'd0, byte_s};
      LD_LH:   data = {{16{half_s[15]}}, half_s};
      LD_LHU:  data = {16'd0, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage with a small pending-write FIFO and forwarding.
// Requests are resolved to final write data at enqueue, buffered, and
// drained into the register-file write port whenever wb_hold is low.
// Ports:
//   clk, rst (async active-low)
//   in_valid/in_ready          request handshake
//   in_wen, in_wreg, in_sel    write enable, destination, data source
//   in_alu_result, in_mem_rdata, in_addr_lo, in_load_type, in_pc
//   wb_hold                    register-file port unavailable
//   RegWrite, wreg, wdata      registered register-file write port
//   rreg_a/b -> fwd_hit_a/b, fwd_data_a/b   combinational forwarding
module reg_writeback
  import mips_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [4:0]  in_wreg,
  input  logic [1:0]  in_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_mem_rdata,
  input  logic [1:0]  in_addr_lo,
  input  logic [2:0]  in_load_type,
  input  logic [31:0] in_pc,
  input  logic        wb_hold,
  output logic        RegWrite,
  output logic [4:0]  wreg,
  output logic [31:0] wdata,
  input  logic [4:0]  rreg_a,
  input  logic [4:0]  rreg_b,
  output logic        fwd_hit_a,
  output logic [31:0] fwd_data_a,
  output logic        fwd_hit_b,
  output logic [31:0] fwd_data_b
);

  localparam int PTR_W = 2;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // Storage is sized for the largest legal DEPTH so the 2-bit pointers
  // index it exactly; only the first DEPTH slots are ever used.
  wb_entry_t         mem_r [4];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic              active_r;
  wb_entry_t         out_r;

  logic              push_s;
  logic              pop_s;
  logic [31:0]       load_data_s;
  logic [31:0]       wdata_sel_s;
  wb_entry_t         new_entry_s;
  logic [32:0]       fwd_a_s;
  logic [32:0]       fwd_b_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + 2'd1;
  endfunction

  // Returns {hit, data}. Candidates are scanned oldest to youngest (output
  // register first, then FIFO head to tail) so the last match wins.
  function automatic logic [32:0] fwd_lookup(
    input logic [4:0]       q,
    input wb_entry_t        ents [4],
    input logic [PTR_W-1:0] head,
    input logic [CNT_W-1:0] count,
    input wb_entry_t        last
  );
    logic             hit;
    logic [31:0]      data;
    logic [PTR_W-1:0] idx;
    logic             match;
    match = last.wen && (last.wreg == q);
    hit   = match;
    data  = match ? last.data : 32'd0;
    idx   = head;
    for (int i = 0; i < DEPTH; i++) begin
      match = (CNT_W'(i) < count) && ents[idx].wen && (ents[idx].wreg == q);
      hit   = match ? 1'b1 : hit;
      data  = match ? ents[idx].data : data;
      idx   = next_ptr(idx);
    end
    if (q == 5'd0) begin
      hit  = 1'b0;
      data = 32'd0;
    end else begin
      hit  = hit;
      data = data;
    end
    return {hit, data};
  endfunction

  wb_load_align u_load_align (
    .rdata     (in_mem_rdata),
    .addr_lo   (in_addr_lo),
    .load_type (in_load_type),
    .data      (load_data_s)
  );

  // active_r keeps in_ready low until the first edge after reset release.
  assign in_ready = active_r && (count_r < DEPTH_C);
  assign push_s   = in_valid && in_ready;
  assign pop_s    = (count_r != 3'd0) && !wb_hold;

  // Write-data source mux; resolved at enqueue so the FIFO holds final data.
  always_comb begin
    wdata_sel_s = in_alu_result;
    case (in_sel)
      SEL_LOAD: wdata_sel_s = load_data_s;
      SEL_LINK: wdata_sel_s = in_pc + LINK_OFFSET;
      default:  wdata_sel_s = in_alu_result;
    endcase
  end

  // Entry formation; writes to register 0 are neutralised here.
  always_comb begin
    new_entry_s.wen  = in_wen && (in_wreg != 5'd0);
    new_entry_s.wreg = in_wreg;
    new_entry_s.data = wdata_sel_s;
  end

  // FIFO pointers, occupancy and storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r   <= 2'd0;
      tail_r   <= 2'd0;
      count_r  <= 3'd0;
      active_r <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mem_r[i] <= 38'd0;
      end
    end else begin
      active_r <= 1'b1;
      if (push_s) begin
        mem_r[tail_r] <= new_entry_s;
        tail_r        <= next_ptr(tail_r);
      end
      if (pop_s) begin
        head_r <= next_ptr(head_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Register-file write port; wreg/wdata hold when nothing is popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r <= 38'd0;
    end else if (pop_s) begin
      out_r <= mem_r[head_r];
    end else begin
      out_r.wen <= 1'b0;
    end
  end

  assign RegWrite = out_r.wen;
  assign wreg     = out_r.wreg;
  assign wdata    = out_r.data;

  // Forwarding lookups for both query ports.
  always_comb begin
    fwd_a_s = fwd_lookup(rreg_a, mem_r, head_r, count_r, out_r);
    fwd_b_s = fwd_lookup(rreg_b, mem_r, head_r, count_r, out_r);
  end

  assign fwd_hit_a  = fwd_a_s[32];
  assign fwd_data_a = fwd_a_s[31:0];
  assign fwd_hit_b  = fwd_b_s[32];
  assign fwd_data_b = fwd_b_s[31:0];

endmodule
